// File: rtl/uart_parity_pkg.sv
// uart_parity_pkg: parity mode encodings and length helpers
// shared by the parity generator and checker.
package uart_parity_pkg;

  localparam int MIN_LEN = 5;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_mode_e;

  function automatic int clamp_len(
    input logic [3:0] len,
    input int         max_w
  );
    int eff;
    eff = int'(len);
    if (eff < MIN_LEN) eff = MIN_LEN;
    if (eff > max_w)   eff = max_w;
    return eff;
  endfunction

  function automatic logic bit_kept(
    input int         idx,
    input logic [3:0] len,
    input int         max_w
  );
    return idx < clamp_len(len, max_w);
  endfunction

  // codes 5..7 behave as none
  function automatic logic par_active(
    input logic [2:0] mode
  );
    logic act;
    case (mode)
      PAR_EVEN,
      PAR_ODD,
      PAR_MARK,
      PAR_SPACE: act = 1'b1;
      default:   act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/uart_parity_if.sv
// uart_parity_if: config, TX capture, RX check and error
// status bundle between UART registers and the parity unit.
interface uart_parity_if #(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_WIDTH = 8
);

  logic [3:0]           data_len;
  logic [2:0]           parity_mode;
  logic [MAX_WIDTH-1:0] DATA;
  logic                 Data_Valid;
  logic                 busy;
  logic                 parity;
  logic                 parity_valid;
  logic [MAX_WIDTH-1:0] chk_data;
  logic                 chk_bit;
  logic                 chk_valid;
  logic                 par_err;
  logic                 err_flag;
  logic [CNT_WIDTH-1:0] err_count;
  logic                 err_clr;

  modport master (
    output data_len,
    output parity_mode,
    output DATA,
    output Data_Valid,
    output busy,
    output chk_data,
    output chk_bit,
    output chk_valid,
    output err_clr,
    input  parity,
    input  parity_valid,
    input  par_err,
    input  err_flag,
    input  err_count
  );

  modport slave (
    input  data_len,
    input  parity_mode,
    input  DATA,
    input  Data_Valid,
    input  busy,
    input  chk_data,
    input  chk_bit,
    input  chk_valid,
    input  err_clr,
    output parity,
    output parity_valid,
    output par_err,
    output err_flag,
    output err_count
  );

endinterface

// File: rtl/uart_parity_core.sv
// uart_parity_core: combinational parity function over a
// length-limited character for one parity mode.
module uart_parity_core
  import uart_parity_pkg::*;
#(
  parameter int MAX_WIDTH = 9
) (
  input  logic [MAX_WIDTH-1:0] i_vec,
  input  logic [3:0]           i_len,
  input  logic [2:0]           i_mode,
  output logic                 o_parity
);

  logic [MAX_WIDTH-1:0] w_vec;

  // re-mask so the core is safe on unmasked input too
  always_comb begin
    w_vec = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      w_vec[i] = i_vec[i] & bit_kept(i, i_len, MAX_WIDTH);
    end
  end

  always_comb begin
    o_parity = 1'b0;
    case (i_mode)
      PAR_EVEN:  o_parity = ^w_vec;
      PAR_ODD:   o_parity = ~^w_vec;
      PAR_MARK:  o_parity = 1'b1;
      PAR_SPACE: o_parity = 1'b0;
      default:   o_parity = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_parity_unit.sv
// uart_parity_unit: two-stage TX parity generator plus RX
// parity checker with sticky flag and saturating counter.
module uart_parity_unit
  import uart_parity_pkg::*;
#(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_parity_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [MAX_WIDTH-1:0] w_dat_m;
  logic [MAX_WIDTH-1:0] w_chk_m;
  logic                 w_cap;
  logic                 w_gen_par;
  logic                 w_chk_par;
  logic                 w_err;

  logic [MAX_WIDTH-1:0] r_cap_data;
  logic [3:0]           r_cap_len;
  logic [2:0]           r_cap_mode;
  logic                 r_cap_vld;
  logic                 r_parity;
  logic                 r_parity_valid;
  logic                 r_par_err;
  logic                 r_err_flag;
  logic [CNT_WIDTH-1:0] r_err_count;

  always_comb begin
    w_dat_m = '0;
    w_chk_m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      w_dat_m[i] = bus.DATA[i]
                 & bit_kept(i, bus.data_len, MAX_WIDTH);
      w_chk_m[i] = bus.chk_data[i]
                 & bit_kept(i, bus.data_len, MAX_WIDTH);
    end
  end

  assign w_cap = bus.Data_Valid && !bus.busy;

  uart_parity_core #(.MAX_WIDTH(MAX_WIDTH)) u_gen (
    .i_vec    (r_cap_data),
    .i_len    (r_cap_len),
    .i_mode   (r_cap_mode),
    .o_parity (w_gen_par)
  );

  uart_parity_core #(.MAX_WIDTH(MAX_WIDTH)) u_chk (
    .i_vec    (w_chk_m),
    .i_len    (bus.data_len),
    .i_mode   (bus.parity_mode),
    .o_parity (w_chk_par)
  );

  assign w_err = bus.chk_valid
              && par_active(bus.parity_mode)
              && (bus.chk_bit != w_chk_par);

  // stage 1: latch masked character with its own config
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cap_vld  <= 1'b0;
      r_cap_data <= '0;
      r_cap_len  <= '0;
      r_cap_mode <= '0;
    end else begin
      r_cap_vld <= w_cap;
      if (w_cap) begin
        r_cap_data <= w_dat_m;
        r_cap_len  <= bus.data_len;
        r_cap_mode <= bus.parity_mode;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_parity       <= 1'b0;
      r_parity_valid <= 1'b0;
    end else begin
      if (r_cap_vld) r_parity <= w_gen_par;
      r_parity_valid <= r_cap_vld
                     && par_active(r_cap_mode);
    end
  end

  // a new error outranks a simultaneous clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_err   <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_par_err <= w_err;
      if (w_err) begin
        r_err_flag <= 1'b1;
        if (bus.err_clr)
          r_err_count <= CNT_WIDTH'(1);
        else if (r_err_count != CNT_MAX)
          r_err_count <= r_err_count + 1'b1;
      end else if (bus.err_clr) begin
        r_err_flag  <= 1'b0;
        r_err_count <= '0;
      end
    end
  end

  assign bus.parity       = r_parity;
  assign bus.parity_valid = r_parity_valid;
  assign bus.par_err      = r_par_err;
  assign bus.err_flag     = r_err_flag;
  assign bus.err_count    = r_err_count;

endmodule

// File: tb/tb_uart_parity_unit.sv
// tb_uart_parity_unit: directed checks of the parity
// generator, checker, counter saturation and reset.
module tb_uart_parity_unit;

  localparam int MW = 9;
  localparam int CW = 2;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  uart_parity_if #(.MAX_WIDTH(MW), .CNT_WIDTH(CW)) bus ();

  uart_parity_unit #(.MAX_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.data_len    = 4'd8;
    bus.parity_mode = 3'd0;
    bus.DATA        = '0;
    bus.Data_Valid  = 1'b0;
    bus.busy        = 1'b0;
    bus.chk_data    = '0;
    bus.chk_bit     = 1'b0;
    bus.chk_valid   = 1'b0;
    bus.err_clr     = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({bus.parity, bus.parity_valid, bus.par_err,
         bus.err_flag, bus.err_count} !== 6'b0) begin
      $display("FAIL reset_state got=%b%b%b%b%0d want=0",
               bus.parity, bus.parity_valid, bus.par_err,
               bus.err_flag, bus.err_count);
      n_fail++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_gen_values();
    logic [3:0]    t_len  [8];
    logic [2:0]    t_mode [8];
    logic [MW-1:0] t_dat  [8];
    logic          t_exp  [8];
    t_len  = '{4'd8, 4'd8, 4'd8, 4'd8,
               4'd7, 4'd2, 4'd15, 4'd5};
    t_mode = '{3'd1, 3'd2, 3'd3, 3'd4,
               3'd1, 3'd1, 3'd1, 3'd1};
    t_dat  = '{9'h0A5, 9'h0A5, 9'h0A5, 9'h0A5,
               9'h1FF, 9'h01F, 9'h1FF, 9'h1E0};
    t_exp  = '{1'b0, 1'b1, 1'b1, 1'b0,
               1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 8; k++) begin
      bus.data_len    = t_len[k];
      bus.parity_mode = t_mode[k];
      bus.DATA        = t_dat[k];
      bus.Data_Valid  = 1'b1;
      tick();
      bus.Data_Valid  = 1'b0;
      n_chk++;
      if (bus.parity_valid !== 1'b0) begin
        $display("FAIL gen_early_pv[%0d] got=%b want=0",
                 k, bus.parity_valid);
        n_fail++;
      end
      tick();
      n_chk++;
      if (bus.parity !== t_exp[k]
          || bus.parity_valid !== 1'b1) begin
        $display("FAIL gen_par[%0d] got=%b/%b want=%b/1",
                 k, bus.parity, bus.parity_valid, t_exp[k]);
        n_fail++;
      end
      tick();
      n_chk++;
      if (bus.parity_valid !== 1'b0
          || bus.parity !== t_exp[k]) begin
        $display("FAIL gen_hold[%0d] got=%b/%b want=%b/0",
                 k, bus.parity, bus.parity_valid, t_exp[k]);
        n_fail++;
      end
    end
  endtask

  task automatic test_none_gen();
    bus.data_len    = 4'd8;
    bus.parity_mode = 3'd0;
    bus.DATA        = 9'h001;
    bus.Data_Valid  = 1'b1;
    tick();
    bus.Data_Valid  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (bus.parity_valid !== 1'b0) begin
        $display("FAIL none_pv[%0d] got=%b want=0",
                 k, bus.parity_valid);
        n_fail++;
      end
    end
  endtask

  task automatic test_busy();
    bus.data_len    = 4'd8;
    bus.parity_mode = 3'd4;
    bus.DATA        = 9'h000;
    bus.Data_Valid  = 1'b1;
    tick();
    bus.Data_Valid  = 1'b0;
    tick();
    tick();
    bus.parity_mode = 3'd1;
    bus.DATA        = 9'h001;
    bus.busy        = 1'b1;
    bus.Data_Valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (bus.parity_valid !== 1'b0
          || bus.parity !== 1'b0) begin
        $display("FAIL busy_block[%0d] got=%b/%b want=0/0",
                 k, bus.parity, bus.parity_valid);
        n_fail++;
      end
    end
    bus.busy = 1'b0;
    tick();
    bus.Data_Valid = 1'b0;
    tick();
    n_chk++;
    if (bus.parity !== 1'b1
        || bus.parity_valid !== 1'b1) begin
      $display("FAIL busy_release got=%b/%b want=1/1",
               bus.parity, bus.parity_valid);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.data_len    = 4'd8;
    bus.parity_mode = 3'd1;
    bus.DATA        = 9'h001;
    bus.Data_Valid  = 1'b1;
    tick();
    bus.DATA        = 9'h003;
    tick();
    bus.Data_Valid  = 1'b0;
    n_chk++;
    if (bus.parity !== 1'b1
        || bus.parity_valid !== 1'b1) begin
      $display("FAIL b2b_first got=%b/%b want=1/1",
               bus.parity, bus.parity_valid);
      n_fail++;
    end
    tick();
    n_chk++;
    if (bus.parity !== 1'b0
        || bus.parity_valid !== 1'b1) begin
      $display("FAIL b2b_second got=%b/%b want=0/1",
               bus.parity, bus.parity_valid);
      n_fail++;
    end
    tick();
    n_chk++;
    if (bus.parity_valid !== 1'b0) begin
      $display("FAIL b2b_end got=%b want=0",
               bus.parity_valid);
      n_fail++;
    end
  endtask

  task automatic test_check_basic();
    bus.data_len    = 4'd8;
    bus.parity_mode = 3'd1;
    bus.chk_data    = 9'h001;
    bus.chk_bit     = 1'b0;
    bus.chk_valid   = 1'b1;
    tick();
    bus.chk_valid   = 1'b0;
    n_chk++;
    if (bus.par_err !== 1'b1 || bus.err_flag !== 1'b1
        || bus.err_count !== 2'd1) begin
      $display("FAIL chk_err got=%b/%b/%0d want=1/1/1",
               bus.par_err, bus.err_flag, bus.err_count);
      n_fail++;
    end
    tick();
    n_chk++;
    if (bus.par_err !== 1'b0 || bus.err_flag !== 1'b1) begin
      $display("FAIL chk_pulse_end got=%b/%b want=0/1",
               bus.par_err, bus.err_flag);
      n_fail++;
    end
    bus.chk_bit   = 1'b1;
    bus.chk_valid = 1'b1;
    tick();
    bus.chk_valid = 1'b0;
    n_chk++;
    if (bus.par_err !== 1'b0 || bus.err_count !== 2'd1) begin
      $display("FAIL chk_ok got=%b/%0d want=0/1",
               bus.par_err, bus.err_count);
      n_fail++;
    end
    bus.parity_mode = 3'd0;
    bus.chk_data    = 9'h155;
    bus.chk_bit     = 1'b0;
    bus.chk_valid   = 1'b1;
    tick();
    bus.chk_bit     = 1'b1;
    tick();
    bus.chk_valid   = 1'b0;
    n_chk++;
    if (bus.par_err !== 1'b0 || bus.err_count !== 2'd1) begin
      $display("FAIL chk_none got=%b/%0d want=0/1",
               bus.par_err, bus.err_count);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    int exp_cnt [5];
    exp_cnt = '{1, 2, 3, 3, 3};
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_chk++;
    if (bus.err_flag !== 1'b0 || bus.err_count !== 2'd0) begin
      $display("FAIL sat_preclr got=%b/%0d want=0/0",
               bus.err_flag, bus.err_count);
      n_fail++;
    end
    bus.data_len    = 4'd8;
    bus.parity_mode = 3'd1;
    bus.chk_data    = 9'h001;
    bus.chk_bit     = 1'b0;
    bus.chk_valid   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++;
      if (int'(bus.err_count) != exp_cnt[k]
          || bus.par_err !== 1'b1) begin
        $display("FAIL sat_cnt[%0d] got=%0d/%b want=%0d/1",
                 k, bus.err_count, bus.par_err, exp_cnt[k]);
        n_fail++;
      end
    end
    bus.err_clr = 1'b1;
    tick();
    n_chk++;
    if (bus.err_count !== 2'd1 || bus.err_flag !== 1'b1
        || bus.par_err !== 1'b1) begin
      $display("FAIL sat_clr_err got=%0d/%b/%b want=1/1/1",
               bus.err_count, bus.err_flag, bus.par_err);
      n_fail++;
    end
    bus.chk_valid = 1'b0;
    tick();
    bus.err_clr = 1'b0;
    n_chk++;
    if (bus.err_count !== 2'd0 || bus.err_flag !== 1'b0
        || bus.par_err !== 1'b0) begin
      $display("FAIL sat_clr got=%0d/%b/%b want=0/0/0",
               bus.err_count, bus.err_flag, bus.par_err);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    bus.data_len    = 4'd8;
    bus.parity_mode = 3'd1;
    bus.DATA        = 9'h001;
    bus.Data_Valid  = 1'b1;
    bus.chk_data    = 9'h001;
    bus.chk_bit     = 1'b0;
    bus.chk_valid   = 1'b1;
    tick();
    bus.chk_valid   = 1'b0;
    tick();
    n_chk++;
    if (bus.parity !== 1'b1 || bus.err_count !== 2'd1) begin
      $display("FAIL rst_setup got=%b/%0d want=1/1",
               bus.parity, bus.err_count);
      n_fail++;
    end
    rst = 1'b1;
    bus.Data_Valid = 1'b0;
    #1;
    n_chk++;
    if (bus.parity !== 1'b0 || bus.parity_valid !== 1'b0
        || bus.err_count !== 2'd0
        || bus.err_flag !== 1'b0) begin
      $display("FAIL rst_async got=%b/%b/%0d/%b want=0/0/0/0",
               bus.parity, bus.parity_valid,
               bus.err_count, bus.err_flag);
      n_fail++;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (bus.parity_valid !== 1'b0
          || bus.parity !== 1'b0) begin
        $display("FAIL rst_after[%0d] got=%b/%b want=0/0",
                 k, bus.parity, bus.parity_valid);
        n_fail++;
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_gen_values();
    test_none_gen();
    test_busy();
    test_back_to_back();
    test_check_basic();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
